// File: rtl/pc_seq.sv
// pc_seq: program-counter sequencer with an integrated return-address stack.
//
// Each rising edge selects the next fetch address, highest priority first:
// start, stall, return, call, absolute jump, PC-relative branch, increment.
//
// Ports:
//   clock_i      single clock, rising edge
//   reset_i      asynchronous active-high reset
//   start_i      load startadd_i, clear RAS count and error flag
//   startadd_i   start address
//   stall_i      hold pc_o and RAS
//   ret_i        pop RAS and jump to the popped address
//   call_i       push pc_o+1 and jump to target_i
//   jump_i       absolute jump to target_i
//   target_i     call/jump target
//   branch_i     PC-relative branch
//   offset_i     signed two's-complement branch offset
//   pc_o         current PC (registered)
//   ras_empty_o  RAS holds no entries
//   ras_full_o   RAS holds RAS_DEPTH entries
//   ras_err_o    sticky overflow/underflow flag

module pc_seq #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned RAS_DEPTH  = 4,
    parameter int unsigned RESET_ADDR = 0
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] startadd_i,
    input  logic             stall_i,
    input  logic             ret_i,
    input  logic             call_i,
    input  logic             jump_i,
    input  logic [WIDTH-1:0] target_i,
    input  logic             branch_i,
    input  logic [WIDTH-1:0] offset_i,
    output logic [WIDTH-1:0] pc_o,
    output logic             ras_empty_o,
    output logic             ras_full_o,
    output logic             ras_err_o
);

    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

    logic [WIDTH-1:0] r_pc;
    logic [PTR_W-1:0] r_top;
    logic [CNT_W-1:0] r_count;
    logic             r_err;
    logic [WIDTH-1:0] r_ras [RAS_DEPTH];

    logic [WIDTH-1:0] w_pc_d;
    logic [PTR_W-1:0] w_top_d;
    logic [CNT_W-1:0] w_count_d;
    logic             w_err_d;
    logic             w_push;
    logic [WIDTH-1:0] w_pc_inc;
    logic             w_empty;
    logic             w_full;

    assign w_pc_inc = r_pc + WIDTH'(1);
    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == FULL_CNT);

    always_comb begin
        w_pc_d    = r_pc;
        w_top_d   = r_top;
        w_count_d = r_count;
        w_err_d   = r_err;
        w_push    = 1'b0;
        if (start_i) begin
            w_pc_d    = startadd_i;
            w_count_d = '0;
            w_err_d   = 1'b0;
        end else if (stall_i) begin
            // hold everything
        end else if (ret_i) begin
            if (!w_empty) begin
                w_pc_d    = r_ras[r_top];
                w_top_d   = r_top - PTR_W'(1);
                w_count_d = r_count - CNT_W'(1);
            end else begin
                w_pc_d  = w_pc_inc;
                w_err_d = 1'b1;
            end
        end else if (call_i) begin
            // On overflow the write at top+1 lands on the oldest entry.
            w_push  = 1'b1;
            w_top_d = r_top + PTR_W'(1);
            w_pc_d  = target_i;
            if (w_full) begin
                w_err_d = 1'b1;
            end else begin
                w_count_d = r_count + CNT_W'(1);
            end
        end else if (jump_i) begin
            w_pc_d = target_i;
        end else if (branch_i) begin
            // WIDTH-bit add of a two's-complement offset is the sign-extended sum.
            w_pc_d = r_pc + offset_i;
        end else begin
            w_pc_d = w_pc_inc;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_pc    <= WIDTH'(RESET_ADDR);
            r_top   <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_pc    <= w_pc_d;
            r_top   <= w_top_d;
            r_count <= w_count_d;
            r_err   <= w_err_d;
        end
    end

    // Stack storage needs no reset; writes are blocked while reset is held.
    always_ff @(posedge clock_i) begin
        if (w_push && !reset_i) begin
            r_ras[w_top_d] <= w_pc_inc;
        end
    end

    assign pc_o        = r_pc;
    assign ras_empty_o = w_empty;
    assign ras_full_o  = w_full;
    assign ras_err_o   = r_err;

endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq: directed self-checking bench for pc_seq (WIDTH=8, RAS_DEPTH=4, RESET_ADDR=0).

module tb_pc_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] startadd;
    logic       stall;
    logic       ret;
    logic       call;
    logic       jump;
    logic [7:0] target;
    logic       branch;
    logic [7:0] offset;
    logic [7:0] pc;
    logic       empty;
    logic       full;
    logic       err;

    int checks   = 0;
    int failures = 0;

    pc_seq #(
        .WIDTH     (8),
        .RAS_DEPTH (4),
        .RESET_ADDR(0)
    ) dut (
        .clock_i    (clk),
        .reset_i    (rst),
        .start_i    (start),
        .startadd_i (startadd),
        .stall_i    (stall),
        .ret_i      (ret),
        .call_i     (call),
        .jump_i     (jump),
        .target_i   (target),
        .branch_i   (branch),
        .offset_i   (offset),
        .pc_o       (pc),
        .ras_empty_o(empty),
        .ras_full_o (full),
        .ras_err_o  (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        start = 0; stall = 0; ret = 0; call = 0; jump = 0; branch = 0;
        startadd = 8'h00; target = 8'h00; offset = 8'h00;
    endtask

    // Apply current inputs for one edge, then return to idle just after it.
    task automatic step();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic chk_all(input string tag, input logic [7:0] epc, input logic ee,
                           input logic ef, input logic er);
        check({tag, ".pc"}, {24'd0, pc}, {24'd0, epc});
        check({tag, ".empty"}, {31'd0, empty}, {31'd0, ee});
        check({tag, ".full"}, {31'd0, full}, {31'd0, ef});
        check({tag, ".err"}, {31'd0, err}, {31'd0, er});
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        #12;
        chk_all("reset", 8'h00, 1, 0, 0);
        // Inputs while reset is high are ignored.
        jump = 1; target = 8'hAA;
        @(posedge clk); #1;
        chk_all("reset_ignore", 8'h00, 1, 0, 0);
        idle_inputs();
        rst = 1'b0;

        step(); check("idle1", {24'd0, pc}, 32'h01);
        step(); check("idle2", {24'd0, pc}, 32'h02);
        step(); check("idle3", {24'd0, pc}, 32'h03);

        start = 1; startadd = 8'hFE; step(); check("start_fe", {24'd0, pc}, 32'hFE);
        step(); check("inc_ff", {24'd0, pc}, 32'hFF);
        step(); check("wrap_00", {24'd0, pc}, 32'h00);

        jump = 1; target = 8'h10; step(); check("jump_10", {24'd0, pc}, 32'h10);
        branch = 1; offset = 8'hFC; step(); check("branch_back", {24'd0, pc}, 32'h0C);
        branch = 1; offset = 8'h05; step(); check("branch_fwd", {24'd0, pc}, 32'h11);
        jump = 1; target = 8'h80; step(); check("jump_80", {24'd0, pc}, 32'h80);
        stall = 1; step(); check("stall1", {24'd0, pc}, 32'h80);
        stall = 1; step(); check("stall2", {24'd0, pc}, 32'h80);
        branch = 1; offset = 8'h80; step(); check("branch_min", {24'd0, pc}, 32'h00);

        // Two-level call/return.
        jump = 1; target = 8'h20; step();
        call = 1; target = 8'h40; step(); chk_all("call1", 8'h40, 0, 0, 0);
        call = 1; target = 8'h60; step(); chk_all("call2", 8'h60, 0, 0, 0);
        ret = 1; step(); chk_all("ret1", 8'h41, 0, 0, 0);
        ret = 1; step(); chk_all("ret2", 8'h21, 1, 0, 0);

        // Five nested calls into a 4-deep stack.
        jump = 1; target = 8'h00; step();
        call = 1; target = 8'h10; step(); chk_all("nest1", 8'h10, 0, 0, 0);
        call = 1; target = 8'h20; step(); chk_all("nest2", 8'h20, 0, 0, 0);
        call = 1; target = 8'h30; step(); chk_all("nest3", 8'h30, 0, 0, 0);
        call = 1; target = 8'h40; step(); chk_all("nest4", 8'h40, 0, 1, 0);
        call = 1; target = 8'h50; step(); chk_all("nest5_ovf", 8'h50, 0, 1, 1);
        ret = 1; step(); chk_all("pop1", 8'h41, 0, 0, 1);
        ret = 1; step(); chk_all("pop2", 8'h31, 0, 0, 1);
        ret = 1; step(); chk_all("pop3", 8'h21, 0, 0, 1);
        ret = 1; step(); chk_all("pop4", 8'h11, 1, 0, 1);
        ret = 1; step(); chk_all("pop5_udf", 8'h12, 1, 0, 1);
        stall = 1; step(); chk_all("stall_keeps_err", 8'h12, 1, 0, 1);

        // Priority: start over call and branch, clears error.
        call = 1; target = 8'h30; step();
        start = 1; startadd = 8'h55; call = 1; target = 8'h99; branch = 1; offset = 8'h07;
        step(); chk_all("prio_start", 8'h55, 1, 0, 0);
        call = 1; target = 8'h70; step(); chk_all("call_after_start", 8'h70, 0, 0, 0);
        stall = 1; ret = 1; step(); chk_all("prio_stall_ret", 8'h70, 0, 0, 0);
        call = 1; ret = 1; target = 8'hC0; step(); chk_all("prio_ret_call", 8'h56, 1, 0, 0);

        // Async reset in the middle of a call sequence.
        jump = 1; target = 8'h30; step();
        call = 1; target = 8'h90; step(); chk_all("pre_reset_call", 8'h90, 0, 0, 0);
        call = 1; target = 8'hA0;
        #3;
        rst = 1'b1;
        #1;
        chk_all("async_reset", 8'h00, 1, 0, 0);
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
        step(); chk_all("post_release", 8'h01, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_seq.md
# pc_seq

Parametrised program-counter sequencer with an integrated return-address stack (RAS). Each cycle it selects the next instruction address from start, stall, return, call, absolute jump, signed PC-relative branch or sequential increment. It sits at the head of the fetch stage and drives the instruction-memory address. It generalises the 8-bit forward/backward-branch PC with configurable width, a signed offset, stall, and call/return support.

## Interface
Parameters:
- WIDTH, 8, address width in bits (≥ 4)
- RAS_DEPTH, 4, return-address stack entries (power of two, ≥ 2)
- RESET_ADDR, 0, pc_o value on reset

Ports:
- clock_i  in  1  single clock; all state updates on rising edge
- reset_i  in  1  reset, asynchronous, active-high
- start_i  in  1  load startadd_i, clear RAS and error flag
- startadd_i  in  WIDTH  start address
- stall_i  in  1  hold pc_o and RAS unchanged
- ret_i  in  1  pop RAS, jump to popped address
- call_i  in  1  push pc_o+1, jump to target_i
- jump_i  in  1  absolute jump to target_i
- target_i  in  WIDTH  absolute target for call/jump
- branch_i  in  1  PC-relative branch
- offset_i  in  WIDTH  signed two's-complement branch offset
- pc_o  out  WIDTH  current PC (registered)
- ras_empty_o  out  1  RAS holds 0 entries
- ras_full_o  out  1  RAS holds RAS_DEPTH entries
- ras_err_o  out  1  sticky: overflow or underflow occurred

## Operation
- Reset (async assert): pc_o=RESET_ADDR, RAS count=0, ras_empty_o=1, ras_full_o=0, ras_err_o=0. RAS contents need no reset.
- Per-edge priority, highest first; exactly one action per cycle:
  1. start_i: pc_o←startadd_i; count←0; ras_err_o←0.
  2. stall_i: no state change.
  3. ret_i: if count>0, pc_o←top entry, count−1. If empty (underflow), pc_o←pc_o+1, count stays 0, ras_err_o←1.
  4. call_i: push pc_o+1 (mod 2^WIDTH); pc_o←target_i. If full (overflow), the oldest entry is discarded (circular buffer), count stays RAS_DEPTH, ras_err_o←1.
  5. jump_i: pc_o←target_i.
  6. branch_i: pc_o←pc_o+sign-extended offset_i, mod 2^WIDTH.
  7. Otherwise: pc_o←pc_o+1, mod 2^WIDTH.
- Arithmetic: all sums are WIDTH bits, and carry/borrow is discarded. offset_i = 2^(WIDTH−1) is the most negative branch.
- RAS: circular array with a top pointer of log2(RAS_DEPTH) bits and a count of 0..RAS_DEPTH. Push writes at top+1. Pop reads at top and then decrements the pointer.
- ras_err_o stays set until start_i or reset. Stall does not clear it.
- The start and stall inputs suppress lower-priority inputs. A simultaneous call_i and ret_i executes ret only.

## Timing
- Single-cycle latency: inputs are sampled at edge N, and pc_o and the flags reflect the result after edge N.
- ras_empty_o, ras_full_o and ras_err_o are registered, or decoded from registered count. They are valid in the same cycle as pc_o.
- A return immediately after a call (back-to-back cycles) returns the just-pushed address, with no bypass hazard.
- A reset asserted mid-sequence forces the reset values immediately, regardless of the clock. Release is synchronous to the next edge; the first action occurs on the first rising edge with reset_i low.
- Any input asserted while reset_i is high is ignored.

## Test plan
- Reset, then 3 idle cycles (WIDTH=8): pc_o = 0,1,2,3. Start with startadd_i=0xFE, then idle: pc_o = 0xFE, 0xFF, 0x00 (wrap).
- At pc_o=0x10: branch with offset_i=0xFC gives 0x0C. Branch with offset 0x05 gives 0x11. Jump with target 0x80 gives 0x80. Stall for 2 cycles holds 0x80.
- At pc_o=0x20: call target 0x40 gives 0x40, ras_empty_o=0. Then call target 0x60 at 0x40 gives 0x60. Ret gives 0x41, and a second ret gives 0x21 with ras_empty_o=1. ras_err_o stays 0 throughout.
- RAS_DEPTH=4: five nested calls from pc_o 0x00, 0x10, 0x20, 0x30, 0x40. ras_full_o=1 after the 4th call and ras_err_o=1 after the 5th. Four returns yield 0x41, 0x31, 0x21, 0x11. A fifth return is an underflow: pc_o=0x12 and ras_err_o stays 1.
- Priority: start+call+branch asserted together → pc_o=startadd_i and RAS cleared. stall+ret → no change. call+ret with count=1 → pop only.
- Async reset asserted between edges during a call sequence: pc_o=RESET_ADDR immediately, flags reset. The first post-release edge increments pc_o to RESET_ADDR+1.
